// File: rtl/transceiver_tlp_deframer_pkg.sv
// Shared definitions for the TLP deframer: K-symbol codes, FSM state
// encoding and the default CRC-16 generator parameters.
package transceiver_tlp_deframer_pkg;

  localparam logic [7:0] K_SOT  = 8'hFB;
  localparam logic [7:0] K_EOT  = 8'hFD;
  localparam logic [7:0] K_IDLE = 8'hBC;

  localparam logic [15:0] CRC_POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_PAYLOAD,
    S_CRC_HI,
    S_CRC_LO,
    S_EOT
  } state_t;

endpackage

// File: rtl/transceiver_crc16_byte.sv
// Combinational byte-serial CRC-16 step, MSB first, no reflection.
// Same function the TX framer uses to generate the trailing CRC.
module transceiver_crc16_byte (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  input  logic [15:0] poly,
  output logic [15:0] crc_out
);

  // Shift the eight data bits through the CRC register, MSB first.
  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      c = {c[14:0], 1'b0} ^ ({16{c[15] ^ data[7 - i]}} & poly);
    end
    crc_out = c;
  end

endmodule

// File: rtl/transceiver_tlp_deframer.sv
// Receive-side TLP deframer: finds frames delimited by K-symbols in the
// {k_en, byte} stream, checks CRC-16 over ID and payload, and pulses
// deliver/ACK, NACK or framing-error results one cycle after the deciding
// symbol. Optional statistics counters: define DEFRAMER_STATS_EN.
module transceiver_tlp_deframer
  import transceiver_tlp_deframer_pkg::*;
#(
  parameter int unsigned TLP_WIDTH = 32,
  parameter logic [15:0] CRC_POLY  = CRC_POLY_DEFAULT,
  parameter logic [15:0] CRC_INIT  = CRC_INIT_DEFAULT
) (
  input  logic                 i_sys_clk_120,
  input  logic                 i_sys_rst_n,
  input  logic                 i_valid,
  input  logic                 i_packet_k_en,
  input  logic [7:0]           i_packet_byte,
  output logic [TLP_WIDTH-1:0] o_tlp,
  output logic [7:0]           o_tlp_id,
  output logic                 o_tlp_valid,
  output logic                 o_ack_req,
  output logic                 o_nack_req,
  output logic                 o_frame_err,
  output logic [7:0]           o_ack_id
`ifdef DEFRAMER_STATS_EN
  ,
  output logic [15:0]          o_stat_good,
  output logic [15:0]          o_stat_crc_err,
  output logic [15:0]          o_stat_frame_err
`endif
);

  localparam int unsigned N  = TLP_WIDTH / 8;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                 state, next_state;
  logic [CW-1:0]          cnt;
  logic [15:0]            crc, crc_next;
  logic [7:0]             id_reg;
  logic [TLP_WIDTH-1:0]   shift_reg;
  logic [7:0]             crc_hi, crc_lo;

  logic is_sot, is_eot;
  logic seed, crc_upd, latch_id, shift_en, lat_hi, lat_lo, cnt_inc;
  logic ev_good, ev_bad, ev_ferr;

  transceiver_crc16_byte u_crc (
    .crc_in  (crc),
    .data    (i_packet_byte),
    .poly    (CRC_POLY),
    .crc_out (crc_next)
  );

  assign is_sot = i_packet_k_en && (i_packet_byte == K_SOT);
  assign is_eot = i_packet_k_en && (i_packet_byte == K_EOT);

  // State register.
  always_ff @(posedge i_sys_clk_120) begin
    if (!i_sys_rst_n) state <= S_IDLE;
    else              state <= next_state;
  end

  // Next-state decode and per-symbol datapath strobes; nothing moves on a stall.
  always_comb begin
    next_state = state;
    seed       = 1'b0;
    crc_upd    = 1'b0;
    latch_id   = 1'b0;
    shift_en   = 1'b0;
    lat_hi     = 1'b0;
    lat_lo     = 1'b0;
    cnt_inc    = 1'b0;
    ev_good    = 1'b0;
    ev_bad     = 1'b0;
    ev_ferr    = 1'b0;
    if (i_valid) begin
      unique case (state)
        S_IDLE: begin
          if (is_sot) begin
            next_state = S_ID;
            seed       = 1'b1;
          end
        end
        S_ID, S_PAYLOAD, S_CRC_HI, S_CRC_LO: begin
          if (i_packet_k_en) begin
            // A stray SOT both flags the broken frame and opens a new one.
            ev_ferr    = 1'b1;
            next_state = is_sot ? S_ID : S_IDLE;
            seed       = is_sot;
          end else begin
            unique case (state)
              S_ID: begin
                latch_id   = 1'b1;
                crc_upd    = 1'b1;
                next_state = S_PAYLOAD;
              end
              S_PAYLOAD: begin
                shift_en = 1'b1;
                crc_upd  = 1'b1;
                if (cnt == LAST) next_state = S_CRC_HI;
                else             cnt_inc    = 1'b1;
              end
              S_CRC_HI: begin
                lat_hi     = 1'b1;
                next_state = S_CRC_LO;
              end
              default: begin
                lat_lo     = 1'b1;
                next_state = S_EOT;
              end
            endcase
          end
        end
        S_EOT: begin
          if (is_eot) begin
            ev_good    = ({crc_hi, crc_lo} == crc);
            ev_bad     = ({crc_hi, crc_lo} != crc);
            next_state = S_IDLE;
          end else begin
            ev_ferr    = 1'b1;
            next_state = is_sot ? S_ID : S_IDLE;
            seed       = is_sot;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Frame datapath: byte counter, running CRC, ID, payload shift and received CRC.
  always_ff @(posedge i_sys_clk_120) begin
    if (!i_sys_rst_n) begin
      cnt       <= '0;
      crc       <= CRC_INIT;
      id_reg    <= '0;
      shift_reg <= '0;
      crc_hi    <= '0;
      crc_lo    <= '0;
    end else begin
      if (seed)          cnt <= '0;
      else if (cnt_inc)  cnt <= cnt + CW'(1);
      if (seed)          crc <= CRC_INIT;
      else if (crc_upd)  crc <= crc_next;
      if (latch_id)      id_reg    <= i_packet_byte;
      if (shift_en)      shift_reg <= TLP_WIDTH'({shift_reg, i_packet_byte});
      if (lat_hi)        crc_hi    <= i_packet_byte;
      if (lat_lo)        crc_lo    <= i_packet_byte;
    end
  end

  // Registered result pulses; delivered TLP and IDs hold between pulses.
  always_ff @(posedge i_sys_clk_120) begin
    if (!i_sys_rst_n) begin
      o_tlp       <= '0;
      o_tlp_id    <= '0;
      o_ack_id    <= '0;
      o_tlp_valid <= 1'b0;
      o_ack_req   <= 1'b0;
      o_nack_req  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_tlp_valid <= ev_good;
      o_ack_req   <= ev_good;
      o_nack_req  <= ev_bad;
      o_frame_err <= ev_ferr;
      if (ev_good) begin
        o_tlp    <= shift_reg;
        o_tlp_id <= id_reg;
      end
      if (ev_good || ev_bad) o_ack_id <= id_reg;
    end
  end

`ifdef DEFRAMER_STATS_EN
  // Saturating result counters.
  always_ff @(posedge i_sys_clk_120) begin
    if (!i_sys_rst_n) begin
      o_stat_good      <= '0;
      o_stat_crc_err   <= '0;
      o_stat_frame_err <= '0;
    end else begin
      if (ev_good && (o_stat_good != '1))      o_stat_good      <= o_stat_good + 16'd1;
      if (ev_bad  && (o_stat_crc_err != '1))   o_stat_crc_err   <= o_stat_crc_err + 16'd1;
      if (ev_ferr && (o_stat_frame_err != '1)) o_stat_frame_err <= o_stat_frame_err + 16'd1;
    end
  end
`endif

endmodule

// File: doc/transceiver_tlp_deframer.md
# transceiver_tlp_deframer

- Receive-side packet decoder. Sits in the link layer, in the sys_clk_120 domain, downstream of the RX packet elastic buffer.
- Consumes the 9-bit symbol stream {k_en, byte} that the TX framer produced. Finds frame boundaries by K-symbols and checks CRC-16 over ID and payload.
- On a good frame it delivers the TLP with its ID and an ACK request; on a bad frame it raises an error/NACK request.

## Interface
Parameters:
- TLP_WIDTH, 32, payload width in bits; multiple of 8, range 8..256
- CRC_POLY, 16'h1021, CRC-16 generator polynomial (non-reflected)
- CRC_INIT, 16'hFFFF, CRC seed loaded at every start-of-TLP

Ports:
- i_sys_clk_120  in  1  sole clock
- i_sys_rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  symbol on i_packet_k_en/i_packet_byte is valid this cycle
- i_packet_k_en  in  1  symbol is a K-character
- i_packet_byte  in  8  symbol byte
- o_tlp  out  TLP_WIDTH  received payload, first byte in MSBs
- o_tlp_id  out  8  received TLP ID
- o_tlp_valid  out  1  one-cycle pulse; o_tlp/o_tlp_id are valid with it
- o_ack_req  out  1  one-cycle pulse, coincident with o_tlp_valid
- o_nack_req  out  1  one-cycle pulse on a CRC error
- o_frame_err  out  1  one-cycle pulse on a framing error
- o_ack_id  out  8  ID for an ACK/NACK; valid with o_ack_req/o_nack_req

## Operation
- Symbols: SOT = K 0xFB, EOT = K 0xFD, IDLE = K 0xBC. Frame format: SOT, ID, N = TLP_WIDTH/8 payload bytes (MSB first), CRC[15:8], CRC[7:0], EOT.
- A cycle with i_valid=0 is a stall: no state, counter or CRC change.
- CRC: MSB-first, byte-serial, no output XOR. Covers ID and payload bytes only. Seeded with CRC_INIT when SOT is accepted.
- FSM states: S_IDLE, S_ID, S_PAYLOAD, S_CRC_HI, S_CRC_LO, S_EOT.
  - S_IDLE: SOT -> S_ID. Any other symbol (data or K) is ignored silently.
  - S_ID: data -> latch ID, update CRC -> S_PAYLOAD.
  - S_PAYLOAD: data -> shift into the payload register and update CRC. The byte counter counts 0..N-1. At N-1 -> S_CRC_HI.
  - S_CRC_HI / S_CRC_LO: data -> latch the received CRC bytes. S_CRC_LO -> S_EOT.
  - S_EOT: EOT -> compare the received CRC with the computed CRC -> S_IDLE.
    - Match: o_tlp_valid and o_ack_req.
    - Mismatch: o_nack_req.
    - o_ack_id = ID in both cases.
- Framing error, in any state except S_IDLE:
  - A K-symbol arriving where data is expected, or a data byte arriving in S_EOT, pulses o_frame_err and moves to S_IDLE.
  - Exception: if the offending symbol is SOT, pulse o_frame_err and go straight to S_ID with the CRC reseeded. The new frame is not lost.
  - A framing error never produces ACK or NACK; the ID is not trusted.
- o_tlp and o_tlp_id hold their last delivered value between pulses. The shift register is separate from the output register, so a partial frame never disturbs o_tlp.
- No backpressure: the consumer must accept a pulse in the cycle it occurs.

## Timing
- Reset (i_sys_rst_n low at a clock edge): state S_IDLE, counter 0, CRC = CRC_INIT. All outputs are 0: o_tlp, o_tlp_id, o_ack_id and every pulse.
- Reset mid-frame discards the partial frame with no pulse. After reset release, only a fresh SOT starts a frame.
- Output latency: all result pulses are registered and assert the cycle after the EOT (or offending) symbol is sampled. They last exactly one cycle.
- Throughput: back-to-back frames with zero IDLE between EOT and the next SOT are supported. Minimum frame spacing is N+5 valid symbols.
- Simultaneous events: the pulses are mutually exclusive by construction. A framing-error pulse and a new frame start in the same cycle is legal, as in the SOT exception above.

## Configuration
- DEFRAMER_STATS_EN defined: adds outputs o_stat_good, o_stat_crc_err and o_stat_frame_err, each 16 bits.
  - They count ack, nack and frame_err pulses respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
- Not defined: these ports and their logic are absent.

## Structure
- Shared package/defines header holds:
  - K-symbol constants K_SOT=8'hFB, K_EOT=8'hFD, K_IDLE=8'hBC;
  - the FSM state encoding;
  - the default CRC_POLY/CRC_INIT.
- Sub-module transceiver_crc16_byte: combinational next-CRC from (crc_in, byte, poly). It is the same function the TX framer uses.
- Everything else lives in one module.

## Test plan
- Good frame, TLP_WIDTH=64:
  - Stimulus: SOT, 0x31, 0x32..0x39, 0x29, 0xB1, EOT (CRC of "123456789" = 0x29B1).
  - Response: o_tlp_valid and o_ack_req one cycle after EOT, o_tlp=64'h3233343536373839, o_tlp_id=o_ack_id=0x31.
- CRC error: same frame with CRC_LO=0xB0 -> o_nack_req with o_ack_id=0x31; no o_tlp_valid; o_tlp unchanged.
- Framing and resync: K 0xBC after 3 payload bytes -> o_frame_err, return to idle. SOT after 2 payload bytes, followed by a full good frame -> one o_frame_err, then a correct delivery.
- Stalls and back-to-back:
  - Random i_valid=0 gaps inside a frame -> identical result, delayed only by the gaps.
  - Two frames with no IDLE between them -> two ack pulses with distinct IDs.
- Reset mid-frame: assert i_sys_rst_n low during S_PAYLOAD, release, then send a trailing CRC plus EOT -> no pulses; all outputs 0.
- Stats, with DEFRAMER_STATS_EN: 3 good, 2 CRC-bad and 1 framing-bad frame -> counters read 3, 2, 1. Preload to 16'hFFFF via forced stimulus and send one more good frame -> counter stays at 16'hFFFF.
